// File: rtl/cpu_axi_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_axi_arbiter
// Merges the instruction-side (read-only) and data-side (read/write) AXI3
// masters onto the single CPU AXI master port.
//
// Neither upstream master observes ar/awready: each holds its valid until the
// response has returned. This block therefore issues every request exactly
// once, absorbs ar/awready itself, and steers read data to the master that
// owns the outstanding read. A short cool-down state after each transaction
// hides the still-asserted valid of the master that just finished.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   i_ar*, i_arvalid      instruction read request (burst/lock/cache/prot fixed)
//   i_r*                  instruction read data
//   d_ar*, d_arvalid      data read request
//   d_r*                  data read data
//   d_aw*, d_awvalid      data write address (held until bvalid)
//   d_w*, d_wready        data write beats
//   d_b*                  data write response
//   m_ar*, m_aw*, m_w*    downstream AXI3 request channels
//   m_r*, m_rready        downstream read data channel
//   m_b*, m_bready        downstream write response channel
// -----------------------------------------------------------------------------
module cpu_axi_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction read master
    input  logic [3:0]  i_arid,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic [3:0]  i_rid,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    // data read master
    input  logic [3:0]  d_arid,
    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic [1:0]  d_arburst,
    input  logic [1:0]  d_arlock,
    input  logic [3:0]  d_arcache,
    input  logic [2:0]  d_arprot,
    input  logic        d_arvalid,
    output logic [3:0]  d_rid,
    output logic [31:0] d_rdata,
    output logic [1:0]  d_rresp,
    output logic        d_rlast,
    output logic        d_rvalid,
    // data write master
    input  logic [3:0]  d_awid,
    input  logic [31:0] d_awaddr,
    input  logic [3:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic [1:0]  d_awburst,
    input  logic [1:0]  d_awlock,
    input  logic [3:0]  d_awcache,
    input  logic [2:0]  d_awprot,
    input  logic        d_awvalid,
    input  logic [3:0]  d_wid,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    input  logic        d_wvalid,
    output logic        d_wready,
    output logic [3:0]  d_bid,
    output logic [1:0]  d_bresp,
    output logic        d_bvalid,
    // downstream master port
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic [1:0]  m_arlock,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [3:0]  m_awid,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic [1:0]  m_awlock,
    output logic [3:0]  m_awcache,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [3:0]  m_wid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [3:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_COOL = 2'd3
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2,
        W_COOL = 2'd3
    } w_state_t;

    // ---------------- read path state ----------------
    r_state_t    r_state_q, r_state_d;
    logic        sel_q, sel_d;             // read owner: 0 = inst, 1 = data
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [3:0]  ar_len_q, ar_len_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [1:0]  ar_burst_q, ar_burst_d;
    logic [1:0]  ar_lock_q, ar_lock_d;
    logic [3:0]  ar_cache_q, ar_cache_d;
    logic [2:0]  ar_prot_q, ar_prot_d;

    // ---------------- write path state ----------------
    w_state_t    w_state_q, w_state_d;
    logic        aw_done_q, aw_done_d;     // AW handshake already seen
    logic        wlast_done_q, wlast_done_d; // final W beat already seen
    logic [3:0]  aw_id_q, aw_id_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [3:0]  aw_len_q, aw_len_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [1:0]  aw_burst_q, aw_burst_d;
    logic [1:0]  aw_lock_q, aw_lock_d;
    logic [3:0]  aw_cache_q, aw_cache_d;
    logic [2:0]  aw_prot_q, aw_prot_d;

    logic        aw_hs_s;
    logic        wlast_hs_s;

    // Upstream IDs are implied by the owning master; the fixed parameters are
    // placed on the bus instead, so the incoming ID fields carry no information.
    logic        unused_ids_s;
    assign unused_ids_s = ^{i_arid, d_arid};

    // Read FSM next-state: fixed data priority, single issue per request
    always_comb begin
        r_state_d  = r_state_q;
        sel_d      = sel_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        ar_lock_d  = ar_lock_q;
        ar_cache_d = ar_cache_q;
        ar_prot_d  = ar_prot_q;
        case (r_state_q)
            R_IDLE: begin
                if (d_arvalid) begin
                    sel_d      = 1'b1;
                    ar_addr_d  = d_araddr;
                    ar_len_d   = d_arlen;
                    ar_size_d  = d_arsize;
                    ar_burst_d = d_arburst;
                    ar_lock_d  = d_arlock;
                    ar_cache_d = d_arcache;
                    ar_prot_d  = d_arprot;
                    r_state_d  = R_ADDR;
                end else if (i_arvalid) begin
                    // instruction fetches are always INCR, normal, unprivileged
                    sel_d      = 1'b0;
                    ar_addr_d  = i_araddr;
                    ar_len_d   = i_arlen;
                    ar_size_d  = i_arsize;
                    ar_burst_d = 2'b01;
                    ar_lock_d  = 2'b00;
                    ar_cache_d = 4'b0000;
                    ar_prot_d  = 3'b000;
                    r_state_d  = R_ADDR;
                end else begin
                    r_state_d  = R_IDLE;
                end
            end
            R_ADDR: begin
                if (m_arready) begin
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_ADDR;
                end
            end
            R_DATA: begin
                if (m_rvalid && m_rlast) begin
                    r_state_d = R_COOL;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            // the finished master's arvalid is still high here; skip one cycle
            R_COOL:  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state and latched AR fields
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            sel_q      <= 1'b0;
            ar_addr_q  <= 32'd0;
            ar_len_q   <= 4'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            ar_lock_q  <= 2'd0;
            ar_cache_q <= 4'd0;
            ar_prot_q  <= 3'd0;
        end else begin
            r_state_q  <= r_state_d;
            sel_q      <= sel_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            ar_lock_q  <= ar_lock_d;
            ar_cache_q <= ar_cache_d;
            ar_prot_q  <= ar_prot_d;
        end
    end

    assign m_arvalid = (r_state_q == R_ADDR);
    assign m_arid    = sel_q ? DATA_ID : INST_ID;
    assign m_araddr  = ar_addr_q;
    assign m_arlen   = ar_len_q;
    assign m_arsize  = ar_size_q;
    assign m_arburst = ar_burst_q;
    assign m_arlock  = ar_lock_q;
    assign m_arcache = ar_cache_q;
    assign m_arprot  = ar_prot_q;
    assign m_rready  = (r_state_q == R_DATA);

    // Read data is steered to the owner only; the other master sees no valid
    assign i_rvalid = m_rready & ~sel_q & m_rvalid;
    assign i_rid    = m_rid;
    assign i_rdata  = m_rdata;
    assign i_rlast  = m_rlast;
    assign d_rvalid = m_rready & sel_q & m_rvalid;
    assign d_rid    = m_rid;
    assign d_rdata  = m_rdata;
    assign d_rresp  = m_rresp;
    assign d_rlast  = m_rlast;

    // AW and the last W beat may complete in either order while in W_REQ
    assign aw_hs_s    = (w_state_q == W_REQ) && !aw_done_q && m_awready;
    assign wlast_hs_s = (w_state_q == W_REQ) && d_wvalid && m_wready && d_wlast;

    // Write FSM next-state and AW field capture
    always_comb begin
        w_state_d    = w_state_q;
        aw_done_d    = aw_done_q;
        wlast_done_d = wlast_done_q;
        aw_id_d      = aw_id_q;
        aw_addr_d    = aw_addr_q;
        aw_len_d     = aw_len_q;
        aw_size_d    = aw_size_q;
        aw_burst_d   = aw_burst_q;
        aw_lock_d    = aw_lock_q;
        aw_cache_d   = aw_cache_q;
        aw_prot_d    = aw_prot_q;
        case (w_state_q)
            W_IDLE: begin
                if (d_awvalid) begin
                    aw_id_d      = d_awid;
                    aw_addr_d    = d_awaddr;
                    aw_len_d     = d_awlen;
                    aw_size_d    = d_awsize;
                    aw_burst_d   = d_awburst;
                    aw_lock_d    = d_awlock;
                    aw_cache_d   = d_awcache;
                    aw_prot_d    = d_awprot;
                    aw_done_d    = 1'b0;
                    wlast_done_d = 1'b0;
                    w_state_d    = W_REQ;
                end else begin
                    w_state_d    = W_IDLE;
                end
            end
            W_REQ: begin
                aw_done_d    = aw_done_q | aw_hs_s;
                wlast_done_d = wlast_done_q | wlast_hs_s;
                if (aw_done_d && wlast_done_d) begin
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_REQ;
                end
            end
            W_RESP: begin
                if (m_bvalid) begin
                    w_state_d = W_COOL;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            // d_awvalid is still high for one cycle after bvalid; ignore it
            W_COOL:  w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state, progress flags and latched AW fields
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q    <= W_IDLE;
            aw_done_q    <= 1'b0;
            wlast_done_q <= 1'b0;
            aw_id_q      <= 4'd0;
            aw_addr_q    <= 32'd0;
            aw_len_q     <= 4'd0;
            aw_size_q    <= 3'd0;
            aw_burst_q   <= 2'd0;
            aw_lock_q    <= 2'd0;
            aw_cache_q   <= 4'd0;
            aw_prot_q    <= 3'd0;
        end else begin
            w_state_q    <= w_state_d;
            aw_done_q    <= aw_done_d;
            wlast_done_q <= wlast_done_d;
            aw_id_q      <= aw_id_d;
            aw_addr_q    <= aw_addr_d;
            aw_len_q     <= aw_len_d;
            aw_size_q    <= aw_size_d;
            aw_burst_q   <= aw_burst_d;
            aw_lock_q    <= aw_lock_d;
            aw_cache_q   <= aw_cache_d;
            aw_prot_q    <= aw_prot_d;
        end
    end

    assign m_awvalid = (w_state_q == W_REQ) && !aw_done_q;
    assign m_awid    = aw_id_q;
    assign m_awaddr  = aw_addr_q;
    assign m_awlen   = aw_len_q;
    assign m_awsize  = aw_size_q;
    assign m_awburst = aw_burst_q;
    assign m_awlock  = aw_lock_q;
    assign m_awcache = aw_cache_q;
    assign m_awprot  = aw_prot_q;

    // W beats pass straight through, but only while a write is in progress
    assign m_wid    = d_wid;
    assign m_wdata  = d_wdata;
    assign m_wstrb  = d_wstrb;
    assign m_wlast  = d_wlast;
    assign m_wvalid = (w_state_q == W_REQ) & d_wvalid;
    assign d_wready = (w_state_q == W_REQ) & m_wready;

    assign m_bready = (w_state_q == W_RESP);
    assign d_bvalid = m_bready & m_bvalid;
    assign d_bid    = m_bid;
    assign d_bresp  = m_bresp;

endmodule
